// File: rtl/dmem_wait_responder.sv
// dmem_wait_responder
//   Memory side of the load/store port's valid/ready request/response handshake.
//   Accepts one word read or write at a time, answers after LATENCY cycles,
//   and holds a word-addressed RAM of DEPTH 32-bit words.
//
//   Parameters:
//     DEPTH   - number of 32-bit words, power of two, 2..4096
//     LATENCY - cycles from request accept edge to resp_valid, 1..15
//
//   Ports:
//     clk, reset            - rising-edge clock, asynchronous active-high reset
//     req_valid / req_ready - request handshake (req_ready only high in IDLE)
//     req_we                - 1 = write, 0 = read
//     req_addr, req_wdata   - byte address and write data
//     resp_valid/resp_ready - response handshake
//     resp_rdata            - read data (0 for writes and errored requests)
//     resp_err              - address error
//     busy                  - transaction in flight
//
//   Optional feature: define DMEM_ADDR_CHECK_EN to flag misaligned or
//   out-of-range addresses with resp_err and suppress their writes. Without
//   it resp_err stays 0 and addresses alias modulo DEPTH*4 bytes.
module dmem_wait_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state, state_next;
  logic [3:0]      cnt, cnt_next;
  logic            accept, enter_resp;

  // Request captured on the accept edge.
  logic            we_q, err_q;
  logic [AW-1:0]   idx_q;
  logic [31:0]     wdata_q;

  // Decoded live request.
  logic [AW-1:0]   req_idx;
  logic            req_err;

  // Transaction being completed on this edge: with LATENCY=1 the response is
  // produced on the accept edge itself, so the live request is used directly.
  logic            cur_we, cur_err;
  logic [AW-1:0]   cur_idx;
  logic [31:0]     cur_wdata;

  logic [31:0]     mem [DEPTH];

  assign req_idx = req_addr[AW+1:2];

`ifdef DMEM_ADDR_CHECK_EN
  assign req_err = (req_addr[1:0] != 2'b00) || (|req_addr[31:AW+2]);
`else
  // Low and high address bits are deliberately ignored so addresses alias.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[31:AW+2], req_addr[1:0]};
  assign req_err = 1'b0;
`endif

  assign req_ready  = (state == IDLE) && !reset;
  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);
  assign accept     = req_valid && req_ready;

  assign cur_we    = (state == IDLE) ? req_we    : we_q;
  assign cur_err   = (state == IDLE) ? req_err   : err_q;
  assign cur_idx   = (state == IDLE) ? req_idx   : idx_q;
  assign cur_wdata = (state == IDLE) ? req_wdata : wdata_q;

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          cnt_next = 4'(LATENCY - 1);
          if (LATENCY > 1) begin
            state_next = WAIT;
          end else begin
            state_next = RESP;
            enter_resp = 1'b1;
          end
        end
      end
      WAIT: begin
        cnt_next = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_next = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= 32'd0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        err_q   <= req_err;
        idx_q   <= req_idx;
        wdata_q <= req_wdata;
      end
      if (enter_resp) begin
        resp_err   <= cur_err;
        resp_rdata <= (cur_we || cur_err) ? 32'd0 : mem[cur_idx];
      end
    end
  end

  // NOTE: the RAM array has no reset; its contents survive reset. A reset
  // forces IDLE asynchronously, so an aborted write never reaches this block.
  always_ff @(posedge clk) begin
    if (enter_resp && cur_we && !cur_err) begin
      mem[cur_idx] <= cur_wdata;
    end
  end

endmodule

// File: tb/tb_dmem_wait_responder.sv
// Testbench for dmem_wait_responder: two instances (LATENCY 2 and 1, DEPTH 64)
// exercised by directed sequences and randomized transactions, checked against
// a word-array reference model indexed by (addr / 4) mod DEPTH.
module tb_dmem_wait_responder;

  localparam int DEPTH = 64;
  localparam int LAT0  = 2;
  localparam int LAT1  = 1;

  logic        clk;
  logic        reset;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_we     [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];
  logic        busy       [2];

  int n_checks = 0;
  int n_errors = 0;
  int n_resp [2];
  int last_wait;
  time last_accept;

  logic [31:0] ref_mem   [2][DEPTH];
  bit          ref_known [2][DEPTH];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    dmem_wait_responder #(
      .DEPTH  (DEPTH),
      .LATENCY(g == 0 ? LAT0 : LAT1)
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_we    (req_we[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .resp_valid(resp_valid[g]),
      .resp_ready(resp_ready[g]),
      .resp_rdata(resp_rdata[g]),
      .resp_err  (resp_err[g]),
      .busy      (busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (resp_valid[i] && resp_ready[i]) n_resp[i]++;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int lat_of(input int d);
    return (d == 0) ? LAT0 : LAT1;
  endfunction

  function automatic int idx_of(input logic [31:0] addr);
    return int'((addr / 4) % DEPTH);
  endfunction

  function automatic bit err_of(input logic [31:0] addr);
`ifdef DMEM_ADDR_CHECK_EN
    return (addr % 4 != 0) || (addr >= DEPTH * 4);
`else
    return (addr != addr);
`endif
  endfunction

  task automatic check_reset_values(input int d);
    check("rst_req_ready",  req_ready[d],  0);
    check("rst_resp_valid", resp_valid[d], 0);
    check("rst_busy",       busy[d],       0);
    check("rst_resp_rdata", resp_rdata[d], 0);
    check("rst_resp_err",   resp_err[d],   0);
  endtask

  // Runs one transaction on instance d. Called and returns at a falling edge.
  // stall = 0 keeps resp_ready high from the start; otherwise the response is
  // held for 'stall' cycles first. hold_next keeps req_valid high after the
  // accept with a write of 0xFF to 0x20 presented.
  task automatic do_txn(input int d, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input int stall, input bit hold_next);
    int          waited;
    int          cyc;
    int          idx;
    bit          exp_err;
    logic [31:0] held;
    idx     = idx_of(addr);
    exp_err = err_of(addr);

    req_valid[d]  = 1'b1;
    req_we[d]     = we;
    req_addr[d]   = addr;
    req_wdata[d]  = wdata;
    resp_ready[d] = (stall == 0);

    waited = 0;
    while (!req_ready[d]) begin
      if (waited == 20) begin
        check("accept_timeout", 0, 1);
        req_valid[d] = 1'b0;
        return;
      end
      @(negedge clk);
      waited++;
    end
    last_wait   = waited;
    last_accept = $time;
    @(negedge clk);

    if (hold_next) begin
      req_we[d]    = 1'b1;
      req_addr[d]  = 32'h20;
      req_wdata[d] = 32'hFF;
    end else begin
      req_valid[d] = 1'b0;
      req_we[d]    = 1'($urandom);
      req_addr[d]  = $urandom;
      req_wdata[d] = $urandom;
    end

    cyc = 1;
    while (!resp_valid[d]) begin
      check("wait_req_ready", req_ready[d], 0);
      check("wait_busy", busy[d], 1);
      if (cyc == 40) begin
        check("resp_timeout", 0, 1);
        return;
      end
      @(negedge clk);
      cyc++;
    end
    check("latency", cyc, lat_of(d));
    check("resp_err", resp_err[d], exp_err);
    if (we || exp_err) check("resp_rdata", resp_rdata[d], 0);
    else if (ref_known[d][idx]) check("resp_rdata", resp_rdata[d], ref_mem[d][idx]);

    held = resp_rdata[d];
    for (int i = 0; i < stall; i++) begin
      check("stall_resp_valid", resp_valid[d], 1);
      check("stall_rdata_stable", resp_rdata[d], held);
      check("stall_req_ready", req_ready[d], 0);
      check("stall_busy", busy[d], 1);
      @(negedge clk);
    end
    resp_ready[d] = 1'b1;
    @(negedge clk);
    if (stall != 0) resp_ready[d] = 1'b0;
    check("done_resp_valid", resp_valid[d], 0);
    check("done_busy", busy[d], 0);
    check("done_req_ready", req_ready[d], 1);

    if (we && !exp_err) begin
      ref_mem[d][idx]   = wdata;
      ref_known[d][idx] = 1'b1;
    end
  endtask

  initial begin
    int  r0;
    time t0;
    logic [31:0] a;

    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 0; req_we[d] = 0; req_addr[d] = 0; req_wdata[d] = 0;
      resp_ready[d] = 0; n_resp[d] = 0;
      for (int i = 0; i < DEPTH; i++) ref_known[d][i] = 1'b0;
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values(0);
    check_reset_values(1);
    reset = 1'b0;
    @(negedge clk);

    // Basic write then read back, with LATENCY 2.
    do_txn(0, 1, 32'h64, 32'h7, 0, 0);
    do_txn(0, 0, 32'h64, 32'h0, 0, 0);
    check("plan1_read_value", resp_rdata[0], 32'h7);

    // Backpressure on a read.
    do_txn(0, 0, 32'h64, 32'h0, 5, 0);

    // Aliasing / address errors.
    do_txn(0, 1, 32'h000, 32'h0BADF00D, 0, 0);
    do_txn(0, 1, 32'h100, 32'hA5A5A5A5, 1, 0);
    do_txn(0, 0, 32'h000, 32'h0, 0, 0);
    do_txn(0, 1, 32'h66, 32'hDEAD0066, 0, 0);
    do_txn(0, 0, 32'h64, 32'h0, 2, 0);

    // Reset in the middle of a write's wait period.
    do_txn(0, 1, 32'h10, 32'h5555AAAA, 0, 0);
    do_txn(0, 0, 32'h10, 32'h0, 0, 0);
    req_valid[0] = 1; req_we[0] = 1; req_addr[0] = 32'h10; req_wdata[0] = 32'h1234;
    check("rst_pre_ready", req_ready[0], 1);
    @(negedge clk);
    req_valid[0] = 0;
    check("rst_pre_busy", busy[0], 1);
    reset = 1'b1;
    #1;
    check_reset_values(0);
    @(negedge clk);
    check_reset_values(0);
    reset = 1'b0;
    @(negedge clk);
    do_txn(0, 0, 32'h10, 32'h0, 0, 0);
    check("rst_read_old", resp_rdata[0], 32'h5555AAAA);

    // LATENCY 1 back-to-back writes with resp_ready high.
    do_txn(1, 1, 32'h0, 32'h11110000, 0, 0);
    t0 = last_accept;
    do_txn(1, 1, 32'h4, 32'h22220004, 0, 0);
    check("b2b_wait1", last_wait, 0);
    check("b2b_spacing1", 32'(last_accept - t0), 20);
    t0 = last_accept;
    do_txn(1, 1, 32'h8, 32'h33330008, 0, 0);
    check("b2b_wait2", last_wait, 0);
    check("b2b_spacing2", 32'(last_accept - t0), 20);
    do_txn(1, 0, 32'h0, 32'h0, 0, 0);
    do_txn(1, 0, 32'h4, 32'h0, 0, 0);
    do_txn(1, 0, 32'h8, 32'h0, 0, 0);

    // Request held during another transaction must wait for IDLE.
    do_txn(0, 1, 32'h20, 32'h00000011, 0, 0);
    r0 = n_resp[0];
    do_txn(0, 0, 32'h20, 32'h0, 3, 1);
    check("hold_first_read", resp_rdata[0], 32'h11);
    do_txn(0, 1, 32'h20, 32'hFF, 0, 0);
    check("hold_accept_wait", last_wait, 0);
    check("hold_resp_count", n_resp[0] - r0, 2);
    do_txn(0, 0, 32'h20, 32'h0, 0, 0);
    check("hold_final_value", resp_rdata[0], 32'hFF);

    // Randomized traffic on both instances.
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 120; n++) begin
        case ($urandom % 8)
          0, 1, 2, 3, 4: a = 32'(($urandom % DEPTH) * 4);
          5:             a = $urandom;
          6:             a = 32'(($urandom % DEPTH) * 4 + ($urandom % 16 + 1) * DEPTH * 4);
          default:       a = 32'(($urandom % DEPTH) * 4 + ($urandom % 3 + 1));
        endcase
        do_txn(d, 1'($urandom), a, $urandom, int'($urandom % 4), 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
